button_debouncer: RTL and testbench
===================================

// Module: button_debouncer
// PURPOSE
//  Debounces one already-synchronized mechanical input (button/switch) and emits a clean level
//  plus single-cycle rise/fall pulses. Sits directly downstream of the 2-flop synchronizer.
//  Its pulses drive board-level control (single-step, run/halt) of the RISC-V core.
//  The input must already be synchronous to clk; no metastability handling is done here.
// PARAMETERS
//  STABLE_CYCLES  1_000_000  consecutive cycles the new value must hold before acceptance (10 ms @100 MHz); >=2
//  CNT_WIDTH      20         stability counter width; must satisfy 2**CNT_WIDTH > STABLE_CYCLES-1
// PORTS
//  clk         in   1  system clock, rising edge
//  rst         in   1  asynchronous, active-low reset (0 = reset asserted)
//  in_sync     in   1  synchronizer output, synchronous to clk
//  level_out   out  1  debounced level (registered)
//  rise_pulse  out  1  one-cycle pulse when level_out goes 0->1 (registered)
//  fall_pulse  out  1  one-cycle pulse when level_out goes 1->0 (registered)
// BEHAVIOUR
//  - Reset (rst==0, async): state=STABLE_LO, cnt=0, level_out=0, rise_pulse=0, fall_pulse=0.
//    Reset mid-wait aborts the pending transition with no pulse; after release, the block
//    requires STABLE_CYCLES high samples before level_out rises, even if in_sync is already high.
//  - FSM, 4 states, all registered:
//    STABLE_LO: in_sync==1 -> WAIT_HI, cnt<=1; else stay, cnt<=0.
//    WAIT_HI:   in_sync==0 -> STABLE_LO, cnt<=0 (bounce, no output change).
//               in_sync==1 and cnt==STABLE_CYCLES-1 -> STABLE_HI, level_out<=1, rise_pulse<=1, cnt<=0.
//               in_sync==1 otherwise -> cnt<=cnt+1.
//    STABLE_HI / WAIT_LO: mirror image with in_sync inverted; completion sets level_out<=0,
//    fall_pulse<=1.
//  - Latency: in_sync first sampled high at edge k and held -> level_out=1 and rise_pulse=1
//    after edge k+STABLE_CYCLES-1, i.e. exactly STABLE_CYCLES high samples.
//  - Pulses are high for exactly one cycle; they are cleared on the next edge. rise_pulse and
//    fall_pulse are never high together.
//  - Boundary: in_sync toggles on the same edge that cnt reaches STABLE_CYCLES-1 -> bounce wins.
//    The state returns to STABLE_x, with no level change and no pulse.
//  - cnt never exceeds STABLE_CYCLES-1 and never wraps; cnt is 0 in both STABLE states.
//  - Unused state encodings recover to STABLE_LO with outputs 0 on the next edge.
//  - No combinational path from in_sync to any output.
// STRUCTURE
//  - Shared package (board_io_pkg): state encoding localparams ST_STABLE_LO=2'd0, ST_WAIT_HI=2'd1,
//    ST_STABLE_HI=2'd2, ST_WAIT_LO=2'd3; DEFAULT_DEBOUNCE_CYCLES constant.
//  - Single module; no sub-module. The counter and FSM are inline with one sequential and one
//    next-state combinational block.
//  - Top level instantiates synchronizer -> button_debouncer per input.
// TESTING (bench uses STABLE_CYCLES=4, CNT_WIDTH=3)
//  1 Reset: hold rst=0 with in_sync=1 for 3 cycles -> all outputs 0.
//    Release rst -> level_out rises only after 4 high samples.
//  2 Clean press: in_sync 0->1 and held -> level_out=1 and rise_pulse=1 after the 4th high edge.
//    rise_pulse returns to 0 on the next edge.
//  3 Bounce: in_sync pattern 1,1,1,0,1,1,1,1 -> no output change through the 0.
//    level_out rises after the final 4 consecutive 1s; exactly one rise_pulse.
//  4 Release: from level_out=1, in_sync=0 held -> fall_pulse=1 and level_out=0 after the 4th low edge.
//    rise_pulse stays 0 throughout.
//  5 Reset mid-wait: in_sync=1 for 2 cycles, assert rst asynchronously between edges.
//    -> outputs 0 immediately, no pulse; after release the count restarts from 0.
//  6 Pulse-width check: 10 random press/release sequences -> each accepted transition gives exactly
//    one one-cycle pulse of the matching type. level_out equals the running parity of the pulses.

Source files
------------

// File: rtl/board_io_pkg.sv
// Shared board-I/O definitions: debouncer state encoding and the default debounce window.
package board_io_pkg;

  localparam logic [1:0] ST_STABLE_LO = 2'd0;
  localparam logic [1:0] ST_WAIT_HI   = 2'd1;
  localparam logic [1:0] ST_STABLE_HI = 2'd2;
  localparam logic [1:0] ST_WAIT_LO   = 2'd3;

  // 10 ms at 100 MHz
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

  typedef enum logic [1:0] {
    STABLE_LO = ST_STABLE_LO,
    WAIT_HI   = ST_WAIT_HI,
    STABLE_HI = ST_STABLE_HI,
    WAIT_LO   = ST_WAIT_LO
  } deb_state_e;

endpackage

// File: rtl/button_debouncer.sv
// Debounces one synchronized input into a clean level plus one-cycle rise/fall pulses.
// Acceptance after STABLE_CYCLES consecutive new-value samples; all outputs registered, no backpressure.
module button_debouncer
  import board_io_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_WIDTH     = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic in_sync,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  deb_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 level_q, level_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // A sample matching the current level during a wait is a bounce, even on the final count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      STABLE_LO: begin
        cnt_d = '0;
        if (in_sync) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HI: begin
        if (!in_sync) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: begin
        cnt_d = '0;
        if (!in_sync) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LO: begin
        if (in_sync) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Randomized bench for button_debouncer: run-length reference model checked every cycle plus literal checks.
module tb_button_debouncer;

  localparam int N  = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst;
  logic in_sync;
  logic level_out, rise_pulse, fall_pulse;

  int n_cmp = 0;
  int n_err = 0;

  button_debouncer #(.STABLE_CYCLES(N), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_sync   (in_sync),
    .level_out (level_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Reference: count consecutive samples that disagree with the accepted level; N of them flips it.
  int   m_run;
  int   m_pulses;
  logic m_lvl, m_rise, m_fall;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run  = 0;
      m_lvl  = 1'b0;
      m_rise = 1'b0;
      m_fall = 1'b0;
    end else begin
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (in_sync != m_lvl) begin
        m_run++;
        if (m_run == N) begin
          m_lvl  = in_sync;
          m_rise = in_sync;
          m_fall = !in_sync;
          m_run  = 0;
          m_pulses++;
        end
      end else begin
        m_run = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("level_model", level_out, m_lvl);
    check("rise_model", rise_pulse, m_rise);
    check("fall_model", fall_pulse, m_fall);
    check("pulse_exclusive", rise_pulse & fall_pulse, 1'b0);
  end

  int d_pulses = 0;
  always @(posedge clk) begin
    #1;
    if (rise_pulse) d_pulses++;
    if (fall_pulse) d_pulses++;
  end

  // Present a value before the next rising edge, then return at the following falling edge.
  task automatic drive(input logic v);
    in_sync = v;
    @(negedge clk);
  endtask

  task automatic check_all(input string name, input logic lvl, input logic r, input logic f);
    check({name, "_level"}, level_out, lvl);
    check({name, "_rise"}, rise_pulse, r);
    check({name, "_fall"}, fall_pulse, f);
  endtask

  logic pat [8];
  logic tgt, start_lvl;
  int   dp0, mp0;

  initial begin
    m_pulses = 0;
    rst      = 1'b0;
    in_sync  = 1'b1;
    repeat (3) @(negedge clk);
    check_all("reset_hold", 1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    // After release the input is already high: still needs N fresh samples.
    repeat (N - 1) begin
      drive(1'b1);
      check_all("post_reset_wait", 1'b0, 1'b0, 1'b0);
    end
    drive(1'b1);
    check_all("post_reset_rise", 1'b1, 1'b1, 1'b0);
    drive(1'b1);
    check_all("rise_cleared", 1'b1, 1'b0, 1'b0);

    repeat (N - 1) begin
      drive(1'b0);
      check_all("release_wait", 1'b1, 1'b0, 1'b0);
    end
    drive(1'b0);
    check_all("release_fall", 1'b0, 1'b0, 1'b1);
    drive(1'b0);
    check_all("fall_cleared", 1'b0, 1'b0, 1'b0);

    repeat (N - 1) begin
      drive(1'b1);
      check_all("press_wait", 1'b0, 1'b0, 1'b0);
    end
    drive(1'b1);
    check_all("press_rise", 1'b1, 1'b1, 1'b0);
    repeat (N) drive(1'b0);
    check_all("press_release", 1'b0, 1'b0, 1'b1);

    // Low sample lands exactly when the count reaches its last value: bounce wins.
    pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      drive(pat[i]);
      check_all("bounce", (i == 7), (i == 7), 1'b0);
    end

    repeat (N) drive(1'b0);
    drive(1'b1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_all("reset_midwait", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (N - 1) begin
      drive(1'b1);
      check_all("midwait_restart", 1'b0, 1'b0, 1'b0);
    end
    drive(1'b1);
    check_all("midwait_rise", 1'b1, 1'b1, 1'b0);

    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_all("reset_while_high", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    in_sync = 1'b0;
    rst     = 1'b1;
    @(negedge clk);

    start_lvl = level_out;
    dp0 = d_pulses;
    mp0 = m_pulses;
    for (int s = 0; s < 10; s++) begin
      tgt = !m_lvl;
      repeat ($urandom_range(0, 5)) drive(1'($urandom_range(0, 1)));
      repeat (N + $urandom_range(0, 2)) drive(tgt);
      check("seq_level", level_out, tgt);
    end
    n_cmp++;
    if ((d_pulses - dp0) != (m_pulses - mp0)) begin
      n_err++;
      $display("FAIL seq_pulse_count: got %0d expected %0d", d_pulses - dp0, m_pulses - mp0);
    end
    check("seq_parity", level_out, start_lvl ^ 1'((d_pulses - dp0) % 2));

    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(0, 3) == 0) drive(!in_sync);
      else drive(in_sync);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
